// File: rtl/fifo_rd_packer.sv
// Read-side consumer of the async FIFO: pops entries through the registered-read port,
// packs PACK entries (first entry in the LSBs) into one word and presents it through a
// 2-entry valid/ready output buffer. A flush pulse emits any partial word with a keep mask.
module fifo_rd_packer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PACK       = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fifo_empty,
    output logic                       fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]      fifo_rd_data,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH*PACK-1:0] out_data,
    output logic [PACK-1:0]            out_keep,
    output logic                       busy
);

    localparam int unsigned OutW = DATA_WIDTH * PACK;
    localparam int unsigned CntW = $clog2(PACK + 1);

    // Assembly state
    logic                run_q;
    logic [CntW-1:0]     cnt_q, cnt_d, cnt_land;
    logic                inflight_q;
    logic                flush_pend_q, flush_pend_d;
    logic [OutW-1:0]     asm_q, asm_d, asm_land;
    logic [CntW:0]       credit;
    logic                pop;

    // Output buffer state
    logic [OutW-1:0]     buf_data_q [2];
    logic [PACK-1:0]     buf_keep_q [2];
    logic                rd_ptr_q;
    logic [1:0]          buf_occ_q, buf_occ_d;
    logic                buf_space;
    logic                push;
    logic                out_pop;
    logic                wr_idx;
    logic                flush_fire;
    logic [PACK-1:0]     push_keep;

    // Pop credit: landed bytes plus the in-flight one must leave room in the word.
    // Depends on registered state only, so fifo_empty never loops back into fifo_rd_en.
    always_comb begin
        credit     = {1'b0, cnt_q} + {{CntW{1'b0}}, inflight_q};
        fifo_rd_en = run_q & ~flush_pend_q & (credit < (CntW + 1)'(PACK));
        pop        = fifo_rd_en & ~fifo_empty;
    end

    // Land the in-flight byte, decide on a word push and update the flush handshake.
    always_comb begin
        asm_land = asm_q;
        cnt_land = cnt_q;
        if (inflight_q) begin
            for (int k = 0; k < int'(PACK); k++) begin
                if (cnt_q == CntW'(k)) begin
                    asm_land[k*DATA_WIDTH +: DATA_WIDTH] = fifo_rd_data;
                end
            end
            cnt_land = cnt_q + CntW'(1);
        end

        buf_space  = (buf_occ_q != 2'd2);
        // Flush completes only once nothing is in flight and the buffer can take a word.
        flush_fire = flush_pend_q & ~inflight_q & buf_space;
        push       = buf_space & ((cnt_land == CntW'(PACK)) | (flush_fire & (cnt_q != '0)));

        for (int k = 0; k < int'(PACK); k++) begin
            push_keep[k] = (CntW'(k) < cnt_land);
        end

        cnt_d = cnt_land;
        asm_d = asm_land;
        // Clearing asm keeps unused slots of a later partial word at zero.
        if (push || flush_fire) begin
            cnt_d = '0;
            asm_d = '0;
        end

        flush_pend_d = flush_pend_q;
        if (!flush_pend_q) begin
            flush_pend_d = flush;
        end else if (flush_fire) begin
            flush_pend_d = 1'b0;
        end
    end

    // Output buffer control and outputs.
    always_comb begin
        out_valid = (buf_occ_q != 2'd0);
        out_pop   = out_valid & out_ready;
        wr_idx    = rd_ptr_q ^ buf_occ_q[0];
        buf_occ_d = buf_occ_q + {1'b0, push} - {1'b0, out_pop};
        out_data  = out_valid ? buf_data_q[rd_ptr_q] : '0;
        out_keep  = out_valid ? buf_keep_q[rd_ptr_q] : '0;
        busy      = flush_pend_q | inflight_q | (cnt_q != '0);
    end

    // Assembly and flush state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q        <= 1'b0;
            cnt_q        <= '0;
            inflight_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            asm_q        <= '0;
        end else begin
            run_q        <= 1'b1;
            cnt_q        <= cnt_d;
            inflight_q   <= pop;
            flush_pend_q <= flush_pend_d;
            asm_q        <= asm_d;
        end
    end

    // Output buffer storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
            buf_keep_q[0] <= '0;
            buf_keep_q[1] <= '0;
            rd_ptr_q      <= 1'b0;
            buf_occ_q     <= 2'd0;
        end else begin
            buf_occ_q <= buf_occ_d;
            if (out_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (push) begin
                buf_data_q[wr_idx] <= asm_land;
                buf_keep_q[wr_idx] <= push_keep;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer: a queue-backed FIFO model feeds bytes, expected
// words are queued as stimulus is driven and compared as the DUT hands words out.
module tb_fifo_rd_packer;

    localparam int unsigned DW = 8;
    localparam int unsigned PK = 4;
    localparam int unsigned OW = DW * PK;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic [PK-1:0] out_keep;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0]    src_q [$];
    logic [PK+OW-1:0] exp_q [$];
    logic [PK+OW-1:0] exp_w;
    int  words_rcvd = 0;
    bit  rand_empty = 1'b0;
    bit  pop_s      = 1'b0;
    int  run_len    = 0;
    int  run_max    = 0;

    fifo_rd_packer #(
        .DATA_WIDTH(DW),
        .PACK      (PK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_keep    (out_keep),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Sample the pop decision mid-cycle and track the longest run of back-to-back pops.
    always @(negedge clk) begin
        pop_s = fifo_rd_en && !fifo_empty;
        if (pop_s) begin
            run_len++;
            if (run_len > run_max) run_max = run_len;
        end else begin
            run_len = 0;
        end
    end

    // FIFO model: registered read, empty flag refreshed after stimulus has been queued.
    always @(posedge clk) begin
        if (pop_s && src_q.size() > 0) fifo_rd_data <= src_q.pop_front();
        #2;
        fifo_empty = (src_q.size() == 0) || (rand_empty && ($urandom_range(0, 2) == 0));
    end

    // Scoreboard: every accepted output word must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            words_rcvd++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL word_unexpected: got data=%h keep=%b, required no word",
                         out_data, out_keep);
            end else begin
                exp_w = exp_q.pop_front();
                if ({out_keep, out_data} !== exp_w) begin
                    errors++;
                    $display("FAIL word_order: got data=%h keep=%b, required data=%h keep=%b",
                             out_data, out_keep, exp_w[OW-1:0], exp_w[PK+OW-1:OW]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_full(input logic [OW-1:0] w);
        for (int k = 0; k < int'(PK); k++) src_q.push_back(w[k*DW +: DW]);
        exp_q.push_back({{PK{1'b1}}, w});
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (!(src_q.size() == 0 && exp_q.size() == 0 && !busy && !out_valid) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_drain: got %0d words pending, busy=%b, required drained in %0d cycles",
                     name, exp_q.size(), busy, budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({fifo_rd_en, out_valid, out_keep, busy, out_data} !== '0) begin
            errors++;
            $display("FAIL reset_during: got rd_en=%b valid=%b keep=%b busy=%b data=%h, required all 0",
                     fifo_rd_en, out_valid, out_keep, busy, out_data);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if ({fifo_rd_en, out_valid, out_keep, busy, out_data} !== '0) begin
            errors++;
            $display("FAIL reset_after: got rd_en=%b valid=%b keep=%b busy=%b data=%h, required all 0",
                     fifo_rd_en, out_valid, out_keep, busy, out_data);
        end
    endtask

    task automatic test_reset_midword();
        out_ready = 1'b1;
        src_q.push_back(8'h11);
        src_q.push_back(8'h22);
        repeat (6) tick();
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midword_hold: got busy=%b valid=%b, required busy=1 valid=0",
                     busy, out_valid);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({fifo_rd_en, out_valid, out_keep, busy, out_data} !== '0) begin
            errors++;
            $display("FAIL midword_in_reset: got rd_en=%b valid=%b keep=%b busy=%b data=%h, required all 0",
                     fifo_rd_en, out_valid, out_keep, busy, out_data);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midword_busy: got %b, required 0", busy);
        end
        push_full(32'hDDCCBBAA);
        wait_drain(60, "midword");
    endtask

    task automatic test_stream();
        int w0 = words_rcvd;
        out_ready = 1'b1;
        push_full(32'h44332211);
        push_full(32'h88776655);
        wait_drain(80, "stream");
        checks++;
        if (words_rcvd - w0 !== 2) begin
            errors++;
            $display("FAIL stream_count: got %0d words, required 2", words_rcvd - w0);
        end
        checks++;
        if (run_max !== int'(PK)) begin
            errors++;
            $display("FAIL stream_rd_run: got longest pop run %0d, required %0d", run_max, PK);
        end
    endtask

    task automatic test_backpressure();
        int w0 = words_rcvd;
        out_ready = 1'b0;
        push_full(32'hA3A2A1A0);
        push_full(32'hB3B2B1B0);
        push_full(32'hC3C2C1C0);
        repeat (30) tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hA3A2A1A0) begin
            errors++;
            $display("FAIL bp_head: got valid=%b data=%h, required valid=1 data=a3a2a1a0",
                     out_valid, out_data);
        end
        checks++;
        if (fifo_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL bp_rd_en: got %b, required 0", fifo_rd_en);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_busy: got %b, required 1", busy);
        end
        checks++;
        if (src_q.size() !== 0) begin
            errors++;
            $display("FAIL bp_all_popped: got %0d bytes left, required 0", src_q.size());
        end
        out_ready = 1'b1;
        wait_drain(60, "bp");
        checks++;
        if (words_rcvd - w0 !== 3) begin
            errors++;
            $display("FAIL bp_count: got %0d words, required 3", words_rcvd - w0);
        end
    endtask

    task automatic test_flush_partial();
        int w0 = words_rcvd;
        out_ready = 1'b1;
        src_q.push_back(8'hA1);
        src_q.push_back(8'hB2);
        src_q.push_back(8'hC3);
        exp_q.push_back({4'b0111, 32'h00C3B2A1});
        repeat (8) tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL fp_hold: got valid=%b busy=%b, required valid=0 busy=1",
                     out_valid, busy);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_drain(30, "fp");
        checks++;
        if (words_rcvd - w0 !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fp_count: got %0d words busy=%b, required 1 word busy=0",
                     words_rcvd - w0, busy);
        end
    endtask

    task automatic test_flush_edges();
        int w0 = words_rcvd;
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (10) tick();
        checks++;
        if (words_rcvd !== w0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty: got %0d words busy=%b valid=%b, required 0 words busy=0 valid=0",
                     words_rcvd - w0, busy, out_valid);
        end
        w0 = words_rcvd;
        src_q.push_back(8'h11);
        src_q.push_back(8'h22);
        exp_q.push_back({4'b0111, 32'h00332211});
        repeat (6) tick();
        // This byte is popped on the same edge that samples the flush pulse.
        src_q.push_back(8'h33);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_pop_busy: got %b, required 1", busy);
        end
        wait_drain(30, "flush_pop");
        checks++;
        if (words_rcvd - w0 !== 1) begin
            errors++;
            $display("FAIL flush_pop_count: got %0d words, required 1", words_rcvd - w0);
        end
    endtask

    task automatic test_random();
        int w0 = words_rcvd;
        int n = 0;
        logic [OW-1:0] acc = '0;
        logic [DW-1:0] b;
        for (int i = 0; i < 1000; i++) begin
            b = DW'($urandom);
            src_q.push_back(b);
            acc[(i % int'(PK))*DW +: DW] = b;
            if (i % int'(PK) == int'(PK) - 1) exp_q.push_back({{PK{1'b1}}, acc});
        end
        rand_empty = 1'b1;
        while (!(src_q.size() == 0 && exp_q.size() == 0 && !busy && !out_valid) && n < 30000) begin
            tick();
            out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        rand_empty = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (n >= 30000) begin
            errors++;
            $display("FAIL rand_drain: got %0d words pending, required drained in 30000 cycles",
                     exp_q.size());
        end
        checks++;
        if (words_rcvd - w0 !== 250) begin
            errors++;
            $display("FAIL rand_count: got %0d words, required 250", words_rcvd - w0);
        end
        checks++;
        if (run_max > int'(PK)) begin
            errors++;
            $display("FAIL rand_rd_run: got longest pop run %0d, required <= %0d", run_max, PK);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_reset_midword();
        test_stream();
        test_backpressure();
        test_flush_partial();
        test_flush_edges();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
